// File: rtl/axi_rd_arbiter_2x1.sv
// Two-master to one-slave AXI4 read arbiter (AR/R channels only).
// One burst in flight at a time, round-robin between ports; port index rides in the ARID MSB.
module axi_rd_arbiter_2x1 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // port 0 (CPU side)
  input  logic [ID_WIDTH-1:0]   s0_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic [7:0]            s0_axi_arlen,
  input  logic [2:0]            s0_axi_arsize,
  input  logic [1:0]            s0_axi_arburst,
  input  logic                  s0_axi_arlock,
  input  logic [3:0]            s0_axi_arcache,
  input  logic [2:0]            s0_axi_arprot,
  input  logic                  s0_axi_arvalid,
  output logic                  s0_axi_arready,
  output logic [ID_WIDTH-1:0]   s0_axi_rid,
  output logic [DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [1:0]            s0_axi_rresp,
  output logic                  s0_axi_rlast,
  output logic                  s0_axi_rvalid,
  input  logic                  s0_axi_rready,
  // port 1 (prefetcher)
  input  logic [ID_WIDTH-1:0]   s1_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic [7:0]            s1_axi_arlen,
  input  logic [2:0]            s1_axi_arsize,
  input  logic [1:0]            s1_axi_arburst,
  input  logic                  s1_axi_arlock,
  input  logic [3:0]            s1_axi_arcache,
  input  logic [2:0]            s1_axi_arprot,
  input  logic                  s1_axi_arvalid,
  output logic                  s1_axi_arready,
  output logic [ID_WIDTH-1:0]   s1_axi_rid,
  output logic [DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [1:0]            s1_axi_rresp,
  output logic                  s1_axi_rlast,
  output logic                  s1_axi_rvalid,
  input  logic                  s1_axi_rready,
  // shared slave port
  output logic [ID_WIDTH:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_q, last_d;
  logic   sel_arvalid;
  logic   sel_rready;
  logic   unused_rid_msb;

  // The RID MSB is informational only; R routing follows grant_q.
  assign unused_rid_msb = m_axi_rid[ID_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign sel_arvalid = grant_q ? s1_axi_arvalid : s0_axi_arvalid;
  assign sel_rready  = grant_q ? s1_axi_rready  : s0_axi_rready;

  always_comb begin
    if (grant_q) begin
      m_axi_arid    = {1'b1, s1_axi_arid};
      m_axi_araddr  = s1_axi_araddr;
      m_axi_arlen   = s1_axi_arlen;
      m_axi_arsize  = s1_axi_arsize;
      m_axi_arburst = s1_axi_arburst;
      m_axi_arlock  = s1_axi_arlock;
      m_axi_arcache = s1_axi_arcache;
      m_axi_arprot  = s1_axi_arprot;
    end else begin
      m_axi_arid    = {1'b0, s0_axi_arid};
      m_axi_araddr  = s0_axi_araddr;
      m_axi_arlen   = s0_axi_arlen;
      m_axi_arsize  = s0_axi_arsize;
      m_axi_arburst = s0_axi_arburst;
      m_axi_arlock  = s0_axi_arlock;
      m_axi_arcache = s0_axi_arcache;
      m_axi_arprot  = s0_axi_arprot;
    end
  end

  // R payload goes to both ports; only the granted port sees rvalid.
  assign s0_axi_rid   = m_axi_rid[ID_WIDTH-1:0];
  assign s0_axi_rdata = m_axi_rdata;
  assign s0_axi_rresp = m_axi_rresp;
  assign s0_axi_rlast = m_axi_rlast;
  assign s1_axi_rid   = m_axi_rid[ID_WIDTH-1:0];
  assign s1_axi_rdata = m_axi_rdata;
  assign s1_axi_rresp = m_axi_rresp;
  assign s1_axi_rlast = m_axi_rlast;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_d         = last_q;
    m_axi_arvalid  = 1'b0;
    m_axi_rready   = 1'b0;
    s0_axi_arready = 1'b0;
    s1_axi_arready = 1'b0;
    s0_axi_rvalid  = 1'b0;
    s1_axi_rvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        // Grant is registered here so arvalid never reaches the slave combinationally.
        if (s0_axi_arvalid || s1_axi_arvalid) begin
          grant_d = (s0_axi_arvalid && s1_axi_arvalid) ? ~last_q : s1_axi_arvalid;
          state_d = ADDR;
        end
      end
      ADDR: begin
        m_axi_arvalid = sel_arvalid;
        if (grant_q) s1_axi_arready = m_axi_arready;
        else         s0_axi_arready = m_axi_arready;
        if (sel_arvalid && m_axi_arready) state_d = DATA;
      end
      DATA: begin
        m_axi_rready = sel_rready;
        if (grant_q) s1_axi_rvalid = m_axi_rvalid;
        else         s0_axi_rvalid = m_axi_rvalid;
        if (m_axi_rvalid && sel_rready && m_axi_rlast) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter_2x1.sv
// Self-checking bench for axi_rd_arbiter_2x1 with a behavioural RAM slave and per-port beat scoreboards.
module tb_axi_rd_arbiter_2x1;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int IW = 8;
  localparam int MEM_WORDS = 4096;

  typedef logic [2+1+IW+DW-1:0] beat_t;  // {rresp, rlast, rid, rdata}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [IW-1:0] s0_axi_arid, s1_axi_arid;
  logic [AW-1:0] s0_axi_araddr, s1_axi_araddr;
  logic [7:0]    s0_axi_arlen, s1_axi_arlen;
  logic [2:0]    s0_axi_arsize, s1_axi_arsize;
  logic [1:0]    s0_axi_arburst, s1_axi_arburst;
  logic          s0_axi_arlock, s1_axi_arlock;
  logic [3:0]    s0_axi_arcache, s1_axi_arcache;
  logic [2:0]    s0_axi_arprot, s1_axi_arprot;
  logic          s0_axi_arvalid = 1'b0, s1_axi_arvalid = 1'b0;
  logic          s0_axi_arready, s1_axi_arready;
  logic [IW-1:0] s0_axi_rid, s1_axi_rid;
  logic [DW-1:0] s0_axi_rdata, s1_axi_rdata;
  logic [1:0]    s0_axi_rresp, s1_axi_rresp;
  logic          s0_axi_rlast, s1_axi_rlast;
  logic          s0_axi_rvalid, s1_axi_rvalid;
  logic          s0_axi_rready = 1'b1, s1_axi_rready = 1'b1;
  logic [IW:0]   m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arlock;
  logic [3:0]    m_axi_arcache;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_arvalid, m_axi_arready;
  logic [IW:0]   m_axi_rid;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi_rd_arbiter_2x1 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .s0_axi_arid(s0_axi_arid), .s0_axi_araddr(s0_axi_araddr), .s0_axi_arlen(s0_axi_arlen),
    .s0_axi_arsize(s0_axi_arsize), .s0_axi_arburst(s0_axi_arburst), .s0_axi_arlock(s0_axi_arlock),
    .s0_axi_arcache(s0_axi_arcache), .s0_axi_arprot(s0_axi_arprot), .s0_axi_arvalid(s0_axi_arvalid),
    .s0_axi_arready(s0_axi_arready), .s0_axi_rid(s0_axi_rid), .s0_axi_rdata(s0_axi_rdata),
    .s0_axi_rresp(s0_axi_rresp), .s0_axi_rlast(s0_axi_rlast), .s0_axi_rvalid(s0_axi_rvalid),
    .s0_axi_rready(s0_axi_rready),
    .s1_axi_arid(s1_axi_arid), .s1_axi_araddr(s1_axi_araddr), .s1_axi_arlen(s1_axi_arlen),
    .s1_axi_arsize(s1_axi_arsize), .s1_axi_arburst(s1_axi_arburst), .s1_axi_arlock(s1_axi_arlock),
    .s1_axi_arcache(s1_axi_arcache), .s1_axi_arprot(s1_axi_arprot), .s1_axi_arvalid(s1_axi_arvalid),
    .s1_axi_arready(s1_axi_arready), .s1_axi_rid(s1_axi_rid), .s1_axi_rdata(s1_axi_rdata),
    .s1_axi_rresp(s1_axi_rresp), .s1_axi_rlast(s1_axi_rlast), .s1_axi_rvalid(s1_axi_rvalid),
    .s1_axi_rready(s1_axi_rready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  int n_checks = 0;
  int n_pass = 0;

  // RAM slave: one burst at a time, beats back-to-back; rresp carries word index bits for tracing.
  logic [DW-1:0] mem [MEM_WORDS];
  logic          ar_en = 1'b1;
  logic          sl_busy = 1'b0;
  logic [IW:0]   sl_id = '0;
  int unsigned   sl_word = 0;
  logic [7:0]    sl_left = '0;

  assign m_axi_arready = ar_en && !sl_busy;
  assign m_axi_rvalid  = sl_busy;
  assign m_axi_rdata   = mem[sl_word % MEM_WORDS];
  assign m_axi_rid     = sl_id;
  assign m_axi_rlast   = (sl_left == 8'd0);
  assign m_axi_rresp   = sl_word[1:0];

  always @(posedge clk) begin
    if (rst) begin
      sl_busy <= 1'b0;
    end else if (sl_busy) begin
      if (m_axi_rready) begin
        if (sl_left == 8'd0) sl_busy <= 1'b0;
        else begin
          sl_word <= sl_word + 1;
          sl_left <= sl_left - 8'd1;
        end
      end
    end else if (m_axi_arvalid && m_axi_arready) begin
      sl_busy <= 1'b1;
      sl_id   <= m_axi_arid;
      sl_word <= 32'(m_axi_araddr >> 2);
      sl_left <= m_axi_arlen;
    end
  end

  // Monitors: delivered beats per port, AR acceptances, stray rvalid on each port.
  beat_t        rx0[$], rx1[$];
  logic [IW:0]  grants[$];
  logic [AW-1:0] ar_addrs[$];
  int s0_rv_cnt = 0;
  int s1_rv_cnt = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (s0_axi_rvalid && s0_axi_rready) rx0.push_back({s0_axi_rresp, s0_axi_rlast, s0_axi_rid, s0_axi_rdata});
      if (s1_axi_rvalid && s1_axi_rready) rx1.push_back({s1_axi_rresp, s1_axi_rlast, s1_axi_rid, s1_axi_rdata});
      if (s0_axi_rvalid) s0_rv_cnt <= s0_rv_cnt + 1;
      if (s1_axi_rvalid) s1_rv_cnt <= s1_rv_cnt + 1;
      if (m_axi_arvalid && m_axi_arready) begin
        grants.push_back(m_axi_arid);
        ar_addrs.push_back(m_axi_araddr);
      end
    end
  end

  // rready pattern per port: 0 = always ready, 1 = toggle each cycle, 2 = random.
  int rr_mode [2] = '{0, 0};
  initial forever begin
    @(posedge clk); #1;
    if (rr_mode[0] == 0) s0_axi_rready = 1'b1;
    else if (rr_mode[0] == 1) s0_axi_rready = ~s0_axi_rready;
    else s0_axi_rready = 1'($urandom_range(0, 1));
    if (rr_mode[1] == 0) s1_axi_rready = 1'b1;
    else if (rr_mode[1] == 1) s1_axi_rready = ~s1_axi_rready;
    else s1_axi_rready = 1'($urandom_range(0, 1));
  end

  // Reference model: a burst of len+1 beats reads consecutive RAM words, last flagged on beat len.
  beat_t       exp0[$], exp1[$];
  logic [IW:0] exp_gr[$];
  bit          ok_bg;

  task automatic expect_burst(input int p, input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len);
    int unsigned w;
    beat_t b;
    for (int i = 0; i <= len; i++) begin
      w = (32'(addr) / 4) + i;
      b = {2'(w % 4), (i == len), id, mem[w % MEM_WORDS]};
      if (p == 0) exp0.push_back(b);
      else exp1.push_back(b);
    end
  endtask

  function automatic beat_t rx_at(input int p, input int i);
    if (p == 0) return (i < rx0.size()) ? rx0[i] : 'x;
    return (i < rx1.size()) ? rx1[i] : 'x;
  endfunction

  function automatic logic [5:0] hs_vec();
    return {m_axi_arvalid, m_axi_rready, s0_axi_arready, s1_axi_arready, s0_axi_rvalid, s1_axi_rvalid};
  endfunction

  task automatic ar_issue(input int p, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, output bit ok);
    ok = 1'b0;
    if (p == 0) begin
      s0_axi_arid = id; s0_axi_araddr = addr; s0_axi_arlen = len; s0_axi_arvalid = 1'b1;
    end else begin
      s1_axi_arid = id; s1_axi_araddr = addr; s1_axi_arlen = len; s1_axi_arvalid = 1'b1;
    end
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if ((p == 0) ? s0_axi_arready : s1_axi_arready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    if (p == 0) s0_axi_arvalid = 1'b0;
    else s1_axi_arvalid = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int n1, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (rx0.size() >= n0 && rx1.size() >= n1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (hs_vec() !== 6'b0) $display("FAIL reset_hs_in_reset: got %b want 000000", hs_vec());
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (hs_vec() !== 6'b0) $display("FAIL reset_hs_after_release: got %b want 000000", hs_vec());
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int b0, b1, v1;
    bit ok;
    b0 = rx0.size(); b1 = rx1.size(); v1 = s1_rv_cnt;
    exp0.delete();
    s0_axi_arid = 8'h12; s0_axi_araddr = 16'h0040; s0_axi_arlen = 8'd3; s0_axi_arvalid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_axi_arvalid !== 1'b0) $display("FAIL single_no_comb_arvalid: got %b want 0", m_axi_arvalid);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (m_axi_arvalid !== 1'b1) $display("FAIL single_arvalid_latency: got %b want 1", m_axi_arvalid);
    else n_pass++;
    n_checks++;
    if (m_axi_arid !== 9'h012) $display("FAIL single_arid: got %h want 012", m_axi_arid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (s0_axi_arready !== 1'b1) $display("FAIL single_arready: got %b want 1", s0_axi_arready);
    else n_pass++;
    @(posedge clk); #1 s0_axi_arvalid = 1'b0;
    expect_burst(0, 8'h12, 16'h0040, 3);
    wait_done(b0 + 4, b1, ok);
    n_checks++;
    if (!ok) $display("FAIL single_timeout: got %0d beats want 4", rx0.size() - b0);
    else n_pass++;
    n_checks++;
    if (rx0.size() - b0 !== exp0.size()) $display("FAIL single_count: got %0d want %0d", rx0.size() - b0, exp0.size());
    else n_pass++;
    foreach (exp0[i]) begin
      n_checks++;
      if (rx_at(0, b0 + i) !== exp0[i]) $display("FAIL single_beat%0d: got %h want %h", i, rx_at(0, b0 + i), exp0[i]);
      else n_pass++;
    end
    n_checks++;
    if (s1_rv_cnt !== v1) $display("FAIL single_s1_rvalid: got %0d cycles want 0", s1_rv_cnt - v1);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int b0, b1, bg;
    bit ok_a, ok_b, ok;
    logic [IW-1:0] id0, id1;
    logic [AW-1:0] a0, a1;
    logic [7:0] l0, l1;
    do_reset();
    b0 = rx0.size(); b1 = rx1.size(); bg = grants.size();
    exp0.delete(); exp1.delete(); exp_gr.delete();
    for (int r = 0; r < 2; r++) begin
      id0 = 8'($urandom); id1 = 8'($urandom);
      a0 = 16'($urandom_range(0, 2000) * 4); a1 = 16'($urandom_range(0, 2000) * 4);
      l0 = 8'($urandom_range(0, 5)); l1 = 8'($urandom_range(0, 5));
      expect_burst(0, id0, a0, int'(l0));
      expect_burst(1, id1, a1, int'(l1));
      exp_gr.push_back({1'b0, id0});
      exp_gr.push_back({1'b1, id1});
      fork
        ar_issue(0, id0, a0, l0, ok_a);
        ar_issue(1, id1, a1, l1, ok_b);
      join
      wait_done(b0 + exp0.size(), b1 + exp1.size(), ok);
      n_checks++;
      if (!(ok && ok_a && ok_b)) $display("FAIL simul_timeout_r%0d: got %0b%0b%0b want 111", r, ok, ok_a, ok_b);
      else n_pass++;
    end
    n_checks++;
    if (grants.size() - bg !== 4) $display("FAIL simul_grant_count: got %0d want 4", grants.size() - bg);
    else n_pass++;
    foreach (exp_gr[i]) begin
      n_checks++;
      if ((bg + i < grants.size() ? grants[bg + i] : 'x) !== exp_gr[i])
        $display("FAIL simul_grant%0d: got %h want %h", i, (bg + i < grants.size() ? grants[bg + i] : 'x), exp_gr[i]);
      else n_pass++;
    end
    foreach (exp0[i]) begin
      n_checks++;
      if (rx_at(0, b0 + i) !== exp0[i]) $display("FAIL simul_s0_beat%0d: got %h want %h", i, rx_at(0, b0 + i), exp0[i]);
      else n_pass++;
    end
    foreach (exp1[i]) begin
      n_checks++;
      if (rx_at(1, b1 + i) !== exp1[i]) $display("FAIL simul_s1_beat%0d: got %h want %h", i, rx_at(1, b1 + i), exp1[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_pressure();
    int b1;
    bit ok_a, ok;
    logic [IW-1:0] id;
    b1 = rx1.size();
    exp1.delete();
    id = 8'($urandom);
    rr_mode[1] = 1;
    expect_burst(1, id, 16'h0400, 7);
    ar_issue(1, id, 16'h0400, 8'd7, ok_a);
    wait_done(rx0.size(), b1 + 8, ok);
    rr_mode[1] = 0;
    n_checks++;
    if (!(ok && ok_a)) $display("FAIL bp_timeout: got %0d beats want 8", rx1.size() - b1);
    else n_pass++;
    n_checks++;
    if (rx1.size() - b1 !== 8) $display("FAIL bp_count: got %0d want 8", rx1.size() - b1);
    else n_pass++;
    foreach (exp1[i]) begin
      n_checks++;
      if (rx_at(1, b1 + i) !== exp1[i]) $display("FAIL bp_beat%0d: got %h want %h", i, rx_at(1, b1 + i), exp1[i]);
      else n_pass++;
    end
  endtask

  task automatic test_single_beat();
    int b0, b1, bg;
    bit ok_a, ok, found;
    logic [IW-1:0] id0, id1;
    b0 = rx0.size(); b1 = rx1.size(); bg = grants.size();
    exp0.delete(); exp1.delete();
    id0 = 8'($urandom); id1 = 8'($urandom);
    expect_burst(1, id1, 16'h0800, 0);
    expect_burst(0, id0, 16'h0100, 1);
    ar_issue(1, id1, 16'h0800, 8'd0, ok_a);
    fork
      ar_issue(0, id0, 16'h0100, 8'd1, ok_bg);
    join_none
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (s1_axi_rvalid && s1_axi_rready) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!(found && ok_a && s1_axi_rlast === 1'b1)) $display("FAIL sbeat_rlast: got %b want 1", s1_axi_rlast);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({m_axi_arvalid, m_axi_rready, s1_axi_rvalid} !== 3'b000)
      $display("FAIL sbeat_idle_after: got %b want 000", {m_axi_arvalid, m_axi_rready, s1_axi_rvalid});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({m_axi_arvalid, m_axi_arid} !== {1'b1, 1'b0, id0})
      $display("FAIL sbeat_next_grant: got %b/%h want 1/%h", m_axi_arvalid, m_axi_arid, {1'b0, id0});
    else n_pass++;
    wait_done(b0 + 2, b1 + 1, ok);
    n_checks++;
    if (!(ok && ok_bg)) $display("FAIL sbeat_timeout: got %0d/%0d want 2/1", rx0.size() - b0, rx1.size() - b1);
    else n_pass++;
    n_checks++;
    if (rx1.size() - b1 !== 1 || rx_at(1, b1) !== exp1[0])
      $display("FAIL sbeat_s1_beat: got %0d beats %h want 1 beat %h", rx1.size() - b1, rx_at(1, b1), exp1[0]);
    else n_pass++;
    foreach (exp0[i]) begin
      n_checks++;
      if (rx_at(0, b0 + i) !== exp0[i]) $display("FAIL sbeat_s0_beat%0d: got %h want %h", i, rx_at(0, b0 + i), exp0[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_burst();
    int b0, b1, bg;
    bit ok_a, ok_b, ok, found;
    logic [IW-1:0] id0, id1;
    b0 = rx0.size();
    id0 = 8'($urandom);
    ar_issue(0, id0, 16'h0200, 8'd5, ok_a);
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (rx0.size() == b0 + 1 && s0_axi_rvalid) begin
        found = 1'b1;
        break;
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (!found || hs_vec() !== 6'b0) $display("FAIL rstmid_hs: got %b (beat2 seen %0b) want 000000", hs_vec(), found);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (hs_vec() !== 6'b0) $display("FAIL rstmid_hs_release: got %b want 000000", hs_vec());
    else n_pass++;
    @(posedge clk); #1;
    // last completed burst before the reset came from port 0, so only the reset makes port 0 win again
    b0 = rx0.size(); b1 = rx1.size(); bg = grants.size();
    exp0.delete(); exp1.delete();
    id0 = 8'($urandom); id1 = 8'($urandom);
    expect_burst(0, id0, 16'h0300, 2);
    expect_burst(1, id1, 16'h0500, 3);
    fork
      ar_issue(0, id0, 16'h0300, 8'd2, ok_a);
      ar_issue(1, id1, 16'h0500, 8'd3, ok_b);
    join
    wait_done(b0 + 3, b1 + 4, ok);
    n_checks++;
    if (!(ok && ok_a && ok_b)) $display("FAIL rstmid_timeout: got %0d/%0d want 3/4", rx0.size() - b0, rx1.size() - b1);
    else n_pass++;
    n_checks++;
    if ((bg < grants.size() ? grants[bg] : 'x) !== {1'b0, id0})
      $display("FAIL rstmid_priority: got %h want %h", (bg < grants.size() ? grants[bg] : 'x), {1'b0, id0});
    else n_pass++;
    foreach (exp1[i]) begin
      n_checks++;
      if (rx_at(1, b1 + i) !== exp1[i]) $display("FAIL rstmid_s1_beat%0d: got %h want %h", i, rx_at(1, b1 + i), exp1[i]);
      else n_pass++;
    end
  endtask

  task automatic test_ar_stall();
    int b0, bg;
    bit ok;
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [2+4+1:0] attr;
    b0 = rx0.size(); bg = grants.size();
    exp0.delete();
    id = 8'($urandom);
    addr = 16'($urandom_range(0, 2000) * 4);
    attr = 8'($urandom);
    {s0_axi_arprot, s0_axi_arcache, s0_axi_arlock} = attr;
    expect_burst(0, id, addr, 2);
    ar_en = 1'b0;
    fork
      ar_issue(0, id, addr, 8'd2, ok_bg);
    join_none
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({m_axi_arvalid, s0_axi_arready, m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arprot, m_axi_arcache, m_axi_arlock}
          !== {1'b1, 1'b0, 1'b0, id, addr, 8'd2, attr})
        $display("FAIL stall_cycle%0d: got %b/%b %h %h %h %h want 1/0 %h %h 02 %h", c, m_axi_arvalid, s0_axi_arready,
                 m_axi_arid, m_axi_araddr, m_axi_arlen, {m_axi_arprot, m_axi_arcache, m_axi_arlock}, {1'b0, id}, addr, attr);
      else n_pass++;
    end
    @(posedge clk); #1 ar_en = 1'b1;
    wait_done(b0 + 3, rx1.size(), ok);
    n_checks++;
    if (!(ok && ok_bg)) $display("FAIL stall_timeout: got %0d beats want 3", rx0.size() - b0);
    else n_pass++;
    n_checks++;
    if (grants.size() - bg !== 1 || (bg < ar_addrs.size() ? ar_addrs[bg] : 'x) !== addr)
      $display("FAIL stall_ar_once: got %0d accepts addr %h want 1 addr %h", grants.size() - bg,
               (bg < ar_addrs.size() ? ar_addrs[bg] : 'x), addr);
    else n_pass++;
    foreach (exp0[i]) begin
      n_checks++;
      if (rx_at(0, b0 + i) !== exp0[i]) $display("FAIL stall_beat%0d: got %h want %h", i, rx_at(0, b0 + i), exp0[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random_traffic();
    int b0, b1, bg, last_served;
    bit ok_a, ok_b, ok;
    bit req0, req1;
    logic [IW-1:0] id0, id1;
    logic [AW-1:0] a0, a1;
    logic [7:0] l0, l1;
    do_reset();
    last_served = 1;
    b0 = rx0.size(); b1 = rx1.size(); bg = grants.size();
    exp0.delete(); exp1.delete(); exp_gr.delete();
    for (int r = 0; r < 10; r++) begin
      req0 = 1'($urandom_range(0, 1));
      req1 = req0 ? 1'($urandom_range(0, 1)) : 1'b1;
      rr_mode[0] = $urandom_range(0, 2);
      rr_mode[1] = $urandom_range(0, 2);
      id0 = 8'($urandom); id1 = 8'($urandom);
      a0 = 16'($urandom_range(0, 4000) * 4); a1 = 16'($urandom_range(0, 4000) * 4);
      l0 = 8'($urandom_range(0, 7)); l1 = 8'($urandom_range(0, 7));
      if (req0) expect_burst(0, id0, a0, int'(l0));
      if (req1) expect_burst(1, id1, a1, int'(l1));
      if (req0 && req1) begin
        // contested: the port not served last goes first
        if (last_served == 1) begin
          exp_gr.push_back({1'b0, id0}); exp_gr.push_back({1'b1, id1});
        end else begin
          exp_gr.push_back({1'b1, id1}); exp_gr.push_back({1'b0, id0});
        end
      end else if (req0) begin
        exp_gr.push_back({1'b0, id0}); last_served = 0;
      end else begin
        exp_gr.push_back({1'b1, id1}); last_served = 1;
      end
      ok_a = 1'b1; ok_b = 1'b1;
      fork
        begin if (req0) ar_issue(0, id0, a0, l0, ok_a); end
        begin if (req1) ar_issue(1, id1, a1, l1, ok_b); end
      join
      wait_done(b0 + exp0.size(), b1 + exp1.size(), ok);
      n_checks++;
      if (!(ok && ok_a && ok_b)) $display("FAIL rand_timeout_r%0d: got %0b%0b%0b want 111", r, ok, ok_a, ok_b);
      else n_pass++;
    end
    rr_mode[0] = 0; rr_mode[1] = 0;
    n_checks++;
    if (rx0.size() - b0 !== exp0.size() || rx1.size() - b1 !== exp1.size())
      $display("FAIL rand_counts: got %0d/%0d want %0d/%0d", rx0.size() - b0, rx1.size() - b1, exp0.size(), exp1.size());
    else n_pass++;
    foreach (exp_gr[i]) begin
      n_checks++;
      if ((bg + i < grants.size() ? grants[bg + i] : 'x) !== exp_gr[i])
        $display("FAIL rand_grant%0d: got %h want %h", i, (bg + i < grants.size() ? grants[bg + i] : 'x), exp_gr[i]);
      else n_pass++;
    end
    foreach (exp0[i]) begin
      n_checks++;
      if (rx_at(0, b0 + i) !== exp0[i]) $display("FAIL rand_s0_beat%0d: got %h want %h", i, rx_at(0, b0 + i), exp0[i]);
      else n_pass++;
    end
    foreach (exp1[i]) begin
      n_checks++;
      if (rx_at(1, b1 + i) !== exp1[i]) $display("FAIL rand_s1_beat%0d: got %h want %h", i, rx_at(1, b1 + i), exp1[i]);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    s0_axi_arid = '0; s0_axi_araddr = '0; s0_axi_arlen = '0; s0_axi_arsize = 3'd2; s0_axi_arburst = 2'b01;
    s0_axi_arlock = 1'b0; s0_axi_arcache = 4'd0; s0_axi_arprot = 3'd0;
    s1_axi_arid = '0; s1_axi_araddr = '0; s1_axi_arlen = '0; s1_axi_arsize = 3'd2; s1_axi_arburst = 2'b01;
    s1_axi_arlock = 1'b0; s1_axi_arcache = 4'd3; s1_axi_arprot = 3'd2;
    test_reset();
    test_single();
    test_simultaneous();
    test_back_pressure();
    test_single_beat();
    test_reset_mid_burst();
    test_ar_stall();
    test_random_traffic();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter_2x1.md
Name: axi_rd_arbiter_2x1

Overview:
- Two-master to one-slave AXI4 read-channel arbiter (AR/R only).
- Shares the axi_ram read port between the CPU-side master (port 0) and the prefetcher (port 1).
- Exactly one burst is in flight at a time: grant, forward AR, stream R beats back until RLAST, release.
- Round-robin fairness; the source port is carried in the MSB of the master-side ARID.

Parameters:
- DATA_WIDTH, 32, data bus width in bits.
- ADDR_WIDTH, 16, address width in bits.
- ID_WIDTH, 8, slave-port ID width. Master-port ID is ID_WIDTH+1 bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- sN_axi_arid  in  ID_WIDTH  read address ID, port N (N=0,1).
- sN_axi_araddr  in  ADDR_WIDTH  read address.
- sN_axi_arlen  in  8  burst length minus 1.
- sN_axi_arsize  in  3  beat size.
- sN_axi_arburst  in  2  burst type.
- sN_axi_arlock/arcache/arprot  in  1/4/3  passed through unchanged.
- sN_axi_arvalid  in  1  AR valid.
- sN_axi_arready  out  1  AR ready.
- sN_axi_rid  out  ID_WIDTH  R ID (master RID with MSB stripped).
- sN_axi_rdata  out  DATA_WIDTH  read data.
- sN_axi_rresp  out  2  read response.
- sN_axi_rlast  out  1  last beat.
- sN_axi_rvalid  out  1  R valid.
- sN_axi_rready  in  1  R ready.
- m_axi_arid  out  ID_WIDTH+1  {grant_port, granted arid}.
- m_axi_araddr/arlen/arsize/arburst/arlock/arcache/arprot  out  as above  muxed from the granted port.
- m_axi_arvalid  out  1  AR valid.
- m_axi_arready  in  1  AR ready.
- m_axi_rid  in  ID_WIDTH+1  R ID.
- m_axi_rdata  in  DATA_WIDTH  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rlast  in  1  last beat.
- m_axi_rvalid  in  1  R valid.
- m_axi_rready  out  1  R ready.

Behaviour:
- Registers: state (IDLE, ADDR, DATA), grant_reg (1 bit), last_reg (1 bit, last port served).
- Reset:
  - state=IDLE, last_reg=1, so port 0 wins the first contest.
  - All valid/ready outputs = 0: m_arvalid, m_rready, s*_arready, s*_rvalid.
- IDLE:
  - All handshake outputs 0.
  - If any sN_arvalid: grant_reg <= winner, state <= ADDR.
  - Winner: the only requester; on simultaneous requests, port !last_reg.
- ADDR:
  - m_axi_ar* = mux(grant_reg).
  - m_axi_arvalid = s[grant]_arvalid; s[grant]_arready = m_axi_arready; other port's arready=0.
  - On m_arvalid&&m_arready: state <= DATA.
  - Arbitration latency: first m_arvalid exactly 1 cycle after sN_arvalid is sampled in IDLE.
- DATA:
  - s[grant]_rvalid = m_rvalid; m_rready = s[grant]_rready; rdata/rresp/rlast forwarded combinationally.
  - s[grant]_rid = m_rid[ID_WIDTH-1:0].
  - Non-granted port: rvalid=0; its rdata/rid/rresp/rlast also driven from master, ignored.
  - On m_rvalid&&m_rready&&m_rlast: last_reg <= grant_reg, state <= IDLE.
  - Earliest next grant is the cycle after RLAST (one idle bubble cycle between bursts).
- Routing uses grant_reg, not the RID MSB. A RID MSB mismatch is still delivered to the granted port (no error flag).
- No combinational path from any sN_arvalid to m_arvalid; grant is always registered.
- A non-granted requester's arvalid is held by it (AXI rule) and is served on the next IDLE.
- rst in any state returns to IDLE the next cycle and drops all valids. The in-flight burst is abandoned; the slave must be reset together with the arbiter.
- arlen=0 (single beat): ADDR to DATA to IDLE with a single R handshake.
- Back-pressure: m_rvalid held while sN_rready=0 stalls DATA indefinitely without losing the beat.

Test Plan:
- Single request: s0 araddr=0x0040, arlen=3, arid=0x12, axi_ram preloaded → m_arid=0x012 one cycle after s0_arvalid; s0 receives 4 beats with rid=0x12, rlast on beat 4; s1_rvalid stays 0 throughout.
- Simultaneous: s0 and s1 arvalid in the same cycle after reset → s0 served first; then s1 with m_arid={1,s1_arid}; then, with both requesting again, s0, then s1 (strict alternation over 4 bursts).
- Back-pressure: s1 arlen=7, s1_rready toggles every cycle → all 8 beats delivered in order, data matches RAM words 0x100..0x107 (word index), no beat duplicated or dropped.
- Single beat: s1 arlen=0 → exactly one beat with rlast=1; state back in IDLE the cycle after the handshake; a pending s0 request is granted on the following cycle.
- Reset mid-burst: assert rst during beat 2 of an arlen=5 burst → next cycle all valid/ready outputs 0; after release, a new s1 request completes normally and port 0 has priority again.
- AR stall: hold m_arready=0 for 5 cycles → m_arvalid and m_ar* stay stable; s[grant]_arready=0; ARADDR accepted exactly once.
